// File: rtl/btb_update_ctrl_if.sv
// Update and BTB-array port bundle for btb_update_ctrl.
// The slave modport is the controller side; master is execute plus the array.
interface btb_update_ctrl_if;
    logic        update_valid;
    logic [15:0] update_pc;
    logic        update_taken;
    logic        update_ready;

    logic        arr_read_req;
    logic [3:0]  arr_read_set;
    logic [9:0]  arr_tag0;
    logic [9:0]  arr_tag1;
    logic [9:0]  arr_tag2;
    logic [9:0]  arr_tag3;

    logic        arr_load;
    logic [9:0]  arr_load_tag;
    logic [3:0]  arr_load_set;
    logic [1:0]  arr_way;

    modport master (
        output update_valid, update_pc, update_taken,
        input  update_ready,
        input  arr_read_req, arr_read_set,
        output arr_tag0, arr_tag1, arr_tag2, arr_tag3,
        input  arr_load, arr_load_tag, arr_load_set, arr_way
    );

    modport slave (
        input  update_valid, update_pc, update_taken,
        output update_ready,
        output arr_read_req, arr_read_set,
        input  arr_tag0, arr_tag1, arr_tag2, arr_tag3,
        output arr_load, arr_load_tag, arr_load_set, arr_way
    );
endinterface

// File: rtl/btb_update_ctrl.sv
// Write-side controller for the 4-way, 16-set BTB tag array: buffers resolved
// branch updates, looks up the target set and allocates/refreshes/invalidates a way.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no update in flight; pops the FIFO head when non-empty
// ST_LOOKUP | array read of the working set; hit/allocation decision
// ST_WRITE  | one-cycle array load of the working tag into the decided way
module btb_update_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  btb_flush,
    btb_update_ctrl_if.slave      bus,
    output logic                  busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;

    logic [1:0]        state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [14:0]       fifo_mem [FIFO_DEPTH];
    logic [14:0]       head;

    logic [9:0]        work_tag;
    logic [3:0]        work_set;
    logic              work_taken;
    logic [1:0]        work_way;

    logic [15:0][3:0]  valid_q;
    logic [15:0][2:0]  plru_q;

    logic              push;
    logic              pop;
    logic [3:0]        set_valid;
    logic [3:0]        hit_vec;
    logic              hit_any;
    logic [1:0]        hit_way;
    logic [1:0]        inv_way;
    logic [1:0]        victim_way;
    logic [1:0]        alloc_way;
    logic [2:0]        set_plru;
    logic              unused_pc_lsb;

    assign unused_pc_lsb = ^bus.update_pc[1:0];

    // PLRU bits are held as {b0, b1, b2}.
    function automatic logic [2:0] plru_touch(input logic [2:0] cur, input logic [1:0] way);
        logic [2:0] nxt;
        case (way)
            2'd0:    nxt = {1'b1, 1'b1, cur[0]};
            2'd1:    nxt = {1'b1, 1'b0, cur[0]};
            2'd2:    nxt = {1'b0, cur[1], 1'b1};
            default: nxt = {1'b0, cur[1], 1'b0};
        endcase
        return nxt;
    endfunction

    assign bus.update_ready = (count != FULL_CNT);
    assign push = bus.update_valid && bus.update_ready && !btb_flush;
    assign pop  = (state == ST_IDLE) && (count != '0);
    assign head = fifo_mem[rd_ptr];
    assign busy = (count != '0) || (state != ST_IDLE);

    always_comb begin
        set_valid  = valid_q[work_set];
        set_plru   = plru_q[work_set];
        hit_vec[0] = set_valid[0] && (bus.arr_tag0 == work_tag);
        hit_vec[1] = set_valid[1] && (bus.arr_tag1 == work_tag);
        hit_vec[2] = set_valid[2] && (bus.arr_tag2 == work_tag);
        hit_vec[3] = set_valid[3] && (bus.arr_tag3 == work_tag);
        hit_any    = |hit_vec;

        if (hit_vec[0])      hit_way = 2'd0;
        else if (hit_vec[1]) hit_way = 2'd1;
        else if (hit_vec[2]) hit_way = 2'd2;
        else                 hit_way = 2'd3;

        if (!set_valid[0])      inv_way = 2'd0;
        else if (!set_valid[1]) inv_way = 2'd1;
        else if (!set_valid[2]) inv_way = 2'd2;
        else                    inv_way = 2'd3;

        if (set_plru[2]) victim_way = set_plru[0] ? 2'd3 : 2'd2;
        else             victim_way = set_plru[1] ? 2'd1 : 2'd0;

        if (hit_any)            alloc_way = hit_way;
        else if (!(&set_valid)) alloc_way = inv_way;
        else                    alloc_way = victim_way;
    end

    always_ff @(posedge clk) begin
        if (push && reset_n) begin
            fifo_mem[wr_ptr] <= {bus.update_taken, bus.update_pc[15:2]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || btb_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            state   <= ST_IDLE;
            valid_q <= '0;
            plru_q  <= '0;
            if (!reset_n) begin
                work_tag   <= '0;
                work_set   <= '0;
                work_taken <= 1'b0;
                work_way   <= '0;
            end
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        work_taken <= head[14];
                        work_tag   <= head[13:4];
                        work_set   <= head[3:0];
                        state      <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (work_taken) begin
                        work_way <= alloc_way;
                        state    <= ST_WRITE;
                    end else begin
                        // Not-taken hit drops the entry; PLRU is left alone.
                        if (hit_any) valid_q[work_set][hit_way] <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    valid_q[work_set][work_way] <= 1'b1;
                    plru_q[work_set]            <= plru_touch(set_plru, work_way);
                    state                       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.arr_read_req = (state == ST_LOOKUP);
    assign bus.arr_read_set = (state == ST_LOOKUP) ? work_set : 4'd0;
    assign bus.arr_load     = (state == ST_WRITE);
    assign bus.arr_load_tag = (state == ST_WRITE) ? work_tag : 10'd0;
    assign bus.arr_load_set = (state == ST_WRITE) ? work_set : 4'd0;
    assign bus.arr_way      = (state == ST_WRITE) ? work_way : 2'd0;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl with a behavioural tag array and a log of
// every array load, compared against hand-computed set/tag/way sequences.
module tb_btb_update_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    logic btb_flush;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;

    btb_update_ctrl_if bif ();

    btb_update_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btb_flush (btb_flush),
        .bus       (bif),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural tag array: combinational read, written on arr_load.
    logic [9:0] tag_mem [16][4];
    assign bif.arr_tag0 = tag_mem[bif.arr_read_set][0];
    assign bif.arr_tag1 = tag_mem[bif.arr_read_set][1];
    assign bif.arr_tag2 = tag_mem[bif.arr_read_set][2];
    assign bif.arr_tag3 = tag_mem[bif.arr_read_set][3];
    always @(posedge clk) begin
        if (bif.arr_load) tag_mem[bif.arr_load_set][bif.arr_way] <= bif.arr_load_tag;
    end

    // Each entry is {way, set, tag}.
    logic [15:0] load_q [$];
    always @(negedge clk) begin
        if (bif.arr_load === 1'b1) load_q.push_back({bif.arr_way, bif.arr_load_set, bif.arr_load_tag});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n          = 1'b0;
        btb_flush        = 1'b0;
        bif.update_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic check_idle_outputs(input string pfx);
        chk({pfx, "_ready"}, bif.update_ready, 1);
        chk({pfx, "_zero_outs"}, {bif.arr_read_req, bif.arr_read_set, bif.arr_load,
                                  bif.arr_load_tag, bif.arr_load_set, bif.arr_way, busy}, 0);
    endtask

    task automatic push(input logic [15:0] pc, input logic taken);
        int guard = 0;
        @(negedge clk);
        bif.update_valid = 1'b1;
        bif.update_pc    = pc;
        bif.update_taken = taken;
        while (bif.update_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("push_ready", bif.update_ready, 1);
        @(posedge clk);
    endtask

    task automatic drop();
        @(negedge clk);
        bif.update_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (busy !== 1'b0 && guard < 200);
        chk({tag, "_drain"}, busy, 0);
    endtask

    task automatic check_load(input string tag, input int idx, input logic [1:0] way,
                              input logic [3:0] set, input logic [9:0] t);
        if (idx >= load_q.size()) chk({tag, "_missing"}, load_q.size(), idx + 1);
        else                      chk(tag, load_q[idx], {way, set, t});
    endtask

    initial begin
        int base;
        int accepts;
        reset_n          = 1'b0;
        btb_flush        = 1'b0;
        bif.update_valid = 1'b0;
        bif.update_pc    = '0;
        bif.update_taken = 1'b0;

        do_reset();
        check_idle_outputs("reset");

        // Fill set 5 with tags 1..4 into ways 0..3.
        base = load_q.size();
        push(16'h0054, 1'b1);
        push(16'h0094, 1'b1);
        push(16'h00D4, 1'b1);
        push(16'h0114, 1'b1);
        drop();
        wait_idle("fill");
        chk("fill_cnt", load_q.size() - base, 4);
        for (int i = 0; i < 4; i++) check_load("fill_load", base + i, 2'(i), 4'd5, 10'(i + 1));

        // PLRU after filling is 000, so the victim is way0.
        base = load_q.size();
        push(16'h0154, 1'b1);
        drop();
        wait_idle("repl");
        check_load("repl_load", base, 2'd0, 4'd5, 10'd5);

        base = load_q.size();
        push(16'h0094, 1'b1);
        drop();
        wait_idle("hit");
        check_load("hit_load", base, 2'd1, 4'd5, 10'd2);

        base = load_q.size();
        push(16'h0094, 1'b0);
        drop();
        wait_idle("inv");
        chk("inv_no_load", load_q.size() - base, 0);

        base = load_q.size();
        push(16'h0194, 1'b1);
        drop();
        wait_idle("realloc");
        check_load("realloc_load", base, 2'd1, 4'd5, 10'd6);

        // PLRU is now b0=1,b1=0,b2=0 with all ways valid: victim way2.
        base = load_q.size();
        push(16'h01D4, 1'b1);
        drop();
        wait_idle("victim");
        check_load("victim_load", base, 2'd2, 4'd5, 10'd7);

        // Latency, then reset in the middle of WRITE.
        do_reset();
        push(16'h0094, 1'b1);
        drop();
        wait_idle("lat_pre");
        push(16'h0054, 1'b1);
        @(negedge clk);
        bif.update_valid = 1'b0;
        chk("lat_n_busy", busy, 1);
        chk("lat_n_rdreq", bif.arr_read_req, 0);
        @(negedge clk);
        chk("lat_n1_lookup", {bif.arr_read_req, bif.arr_read_set, bif.arr_load}, {1'b1, 4'd5, 1'b0});
        @(negedge clk);
        chk("lat_n2_write", {bif.arr_read_req, bif.arr_load, bif.arr_way, bif.arr_load_set, bif.arr_load_tag},
            {1'b0, 1'b1, 2'd1, 4'd5, 10'd1});
        reset_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        reset_n = 1'b1;
        base = load_q.size();
        push(16'h0054, 1'b1);
        drop();
        wait_idle("rst_after");
        check_load("rst_after_load", base, 2'd0, 4'd5, 10'd1);

        // Backpressure: pops at edges 2 and 5 with pushes every edge leave
        // the count at 4 after the sixth accept.
        do_reset();
        base    = load_q.size();
        accepts = 0;
        while (accepts < 16) begin
            @(negedge clk);
            if (bif.update_ready !== 1'b1) break;
            bif.update_valid = 1'b1;
            bif.update_pc    = 16'(((accepts + 1) << 6) | (accepts << 2));
            bif.update_taken = 1'b1;
            @(posedge clk);
            accepts++;
        end
        bif.update_valid = 1'b0;
        chk("bp_accepts", accepts, 6);
        chk("bp_ready_low", bif.update_ready, 0);
        wait_idle("bp");
        chk("bp_cnt", load_q.size() - base, accepts);
        for (int k = 0; k < 6; k++) check_load("bp_order", base + k, 2'd0, 4'(k), 10'(k + 1));

        // Flush while the second update is in LOOKUP with three queued.
        do_reset();
        base = load_q.size();
        push(16'h0094, 1'b1);
        push(16'h0044, 1'b1);
        push(16'h0088, 1'b1);
        push(16'h00CC, 1'b1);
        push(16'h0110, 1'b1);
        @(negedge clk);
        chk("fl_pre_lookup", {bif.arr_read_req, bif.arr_read_set}, {1'b1, 4'd1});
        btb_flush        = 1'b1;
        bif.update_valid = 1'b1;
        bif.update_pc    = 16'h0254;
        bif.update_taken = 1'b1;
        @(negedge clk);
        btb_flush        = 1'b0;
        bif.update_valid = 1'b0;
        chk("fl_busy", busy, 0);
        chk("fl_ready", bif.update_ready, 1);
        chk("fl_rdreq", bif.arr_read_req, 0);
        repeat (3) @(negedge clk);
        chk("fl_no_push", busy, 0);
        chk("fl_cnt", load_q.size() - base, 1);
        check_load("fl_first", base, 2'd0, 4'd5, 10'd2);
        base = load_q.size();
        push(16'h0054, 1'b1);
        drop();
        wait_idle("fl_after");
        check_load("fl_after_load", base, 2'd0, 4'd5, 10'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
